// File: rtl/mfp_ahb_ram_loader.sv
// Byte-stream to AHB-Lite RAM loader: packs four bytes per word and issues single NONSEQ writes.
// Define MFP_RAM_LOADER_CHECKSUM_EN to build the running modulo-2^32 checksum of written words.
module mfp_ahb_ram_loader #(
  parameter int BIG_ENDIAN = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {IDLE, COLLECT, ADDR, DATA, FINISH} state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] addr;
  logic [15:0] count;
  logic [1:0]  byte_idx;
  logic [1:0]  lane;
  logic [31:0] word;
  logic        load;
  logic        byte_take;
  logic        word_done;

  assign load      = (state == IDLE) && start;
  assign byte_take = (state == COLLECT) && rx_valid;
  assign word_done = (state == DATA) && HREADY;
  // Big-endian mode mirrors the lane so the first byte lands in HWDATA[31:24].
  assign lane      = (BIG_ENDIAN != 0) ? ~byte_idx : byte_idx;

  assign HADDR  = addr;
  assign HWDATA = word;
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    rx_ready   = 1'b0;
    HTRANS     = TRANS_IDLE;
    HWRITE     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = (word_count != 16'd0) ? COLLECT : FINISH;
      end
      COLLECT: begin
        rx_ready = 1'b1;
        if (rx_valid && (byte_idx == 2'd3)) next_state = ADDR;
      end
      ADDR: begin
        HTRANS     = TRANS_NONSEQ;
        HWRITE     = 1'b1;
        next_state = DATA;
      end
      DATA: begin
        if (HREADY) next_state = (count == 16'd1) ? FINISH : COLLECT;
      end
      FINISH: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        busy       = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

  // Reset clears the partial word and byte index, so an interrupted load leaves nothing behind.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr     <= 32'd0;
      count    <= 16'd0;
      byte_idx <= 2'd0;
      word     <= 32'd0;
    end else begin
      if (load) begin
        addr     <= base_addr;
        count    <= word_count;
        byte_idx <= 2'd0;
      end
      if (byte_take) begin
        word[{lane, 3'b000} +: 8] <= rx_data;
        byte_idx                  <= byte_idx + 2'd1;
      end
      if (word_done) begin
        addr  <= addr + 32'd4;
        count <= count - 16'd1;
      end
    end
  end

`ifdef MFP_RAM_LOADER_CHECKSUM_EN
  logic [31:0] sum;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)       sum <= 32'd0;
    else if (load)      sum <= 32'd0;
    else if (word_done) sum <= sum + word;
  end

  assign checksum = sum;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_mfp_ahb_ram_loader.sv
// Bench for mfp_ahb_ram_loader: little- and big-endian instances share stimulus and are checked
// every cycle against a transaction-level model, plus literal expectations per scenario.
module tb_mfp_ahb_ram_loader;

  logic        HCLK;
  logic        HRESETn;
  logic        start;
  logic        start_real;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        HREADY;

  logic [31:0] haddr_o[2];
  logic [31:0] hwdata_o[2];
  logic [31:0] checksum_o[2];
  logic [1:0]  htrans_o[2];
  logic [2:0]  hsize_o[2];
  logic [2:0]  hburst_o[2];
  logic        hwrite_o[2];
  logic        rx_ready_o[2];
  logic        busy_o[2];
  logic        done_o[2];

  int errors = 0;
  int checks = 0;

  mfp_ahb_ram_loader #(.BIG_ENDIAN(0)) u_le (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .base_addr(base_addr),
    .word_count(word_count), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready_o[0]),
    .HADDR(haddr_o[0]), .HTRANS(htrans_o[0]), .HWRITE(hwrite_o[0]), .HSIZE(hsize_o[0]),
    .HBURST(hburst_o[0]), .HWDATA(hwdata_o[0]), .HREADY(HREADY), .busy(busy_o[0]),
    .done(done_o[0]), .checksum(checksum_o[0])
  );

  mfp_ahb_ram_loader #(.BIG_ENDIAN(1)) u_be (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .base_addr(base_addr),
    .word_count(word_count), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready_o[1]),
    .HADDR(haddr_o[1]), .HTRANS(htrans_o[1]), .HWRITE(hwrite_o[1]), .HSIZE(hsize_o[1]),
    .HBURST(hburst_o[1]), .HWDATA(hwdata_o[1]), .HREADY(HREADY), .busy(busy_o[1]),
    .done(done_o[1]), .checksum(checksum_o[1])
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Model state: a load is a list of words formed from accepted bytes, written to base+4k.
  logic        active = 1'b0;
  logic        in_phase = 1'b0;
  logic        done_arm = 1'b0;
  logic        exp_done, exp_busy, exp_ns, exp_rdy;
  logic [31:0] job_base = 32'd0;
  int          job_cnt = 0;
  int          acc = 0;
  int          seen = 0;
  int          dlen = 0;
  int          last_dlen = 0;
  int          busy_cnt = 0;
  int          nonseq_cnt = 0;
  logic [7:0]  hist[64];
  logic [31:0] sum_m[2];
  logic [31:0] wlog_addr[16];
  logic [31:0] wlog_data[2][16];

  function automatic logic [31:0] model_word(input int inst, input int k);
    int b = 4 * k;
    if (inst == 0) return {hist[b+3], hist[b+2], hist[b+1], hist[b]};
    return {hist[b], hist[b+1], hist[b+2], hist[b+3]};
  endfunction

  initial begin : compare
    sum_m[0] = 32'd0;
    sum_m[1] = 32'd0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        for (int i = 0; i < 2; i++) begin
          check_output($sformatf("rst_busy[%0d]", i), 32'(busy_o[i]), 32'd0);
          check_output($sformatf("rst_done[%0d]", i), 32'(done_o[i]), 32'd0);
          check_output($sformatf("rst_rx_ready[%0d]", i), 32'(rx_ready_o[i]), 32'd0);
          check_output($sformatf("rst_htrans[%0d]", i), 32'(htrans_o[i]), 32'd0);
          check_output($sformatf("rst_hwrite[%0d]", i), 32'(hwrite_o[i]), 32'd0);
          check_output($sformatf("rst_haddr[%0d]", i), haddr_o[i], 32'd0);
          check_output($sformatf("rst_hwdata[%0d]", i), hwdata_o[i], 32'd0);
          check_output($sformatf("rst_checksum[%0d]", i), checksum_o[i], 32'd0);
        end
        active = 1'b0; in_phase = 1'b0; done_arm = 1'b0;
        acc = 0; seen = 0;
        sum_m[0] = 32'd0; sum_m[1] = 32'd0;
      end else begin
        if (busy_o[0]) busy_cnt++;
        exp_done = done_arm;
        done_arm = 1'b0;
        exp_busy = active;
        exp_ns   = active && !in_phase && (seen < job_cnt) && (acc == 4 * (seen + 1));
        exp_rdy  = active && !exp_done && !in_phase && !exp_ns && (seen < job_cnt);
        for (int i = 0; i < 2; i++) begin
          check_output($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(exp_busy));
          check_output($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(exp_done));
          check_output($sformatf("rx_ready[%0d]", i), 32'(rx_ready_o[i]), 32'(exp_rdy));
          check_output($sformatf("htrans[%0d]", i), 32'(htrans_o[i]), exp_ns ? 32'd2 : 32'd0);
          check_output($sformatf("hwrite[%0d]", i), 32'(hwrite_o[i]), 32'(exp_ns));
          check_output($sformatf("hsize[%0d]", i), 32'(hsize_o[i]), 32'd2);
          check_output($sformatf("hburst[%0d]", i), 32'(hburst_o[i]), 32'd0);
          check_output($sformatf("checksum[%0d]", i), checksum_o[i], sum_m[i]);
          if (exp_ns)
            check_output($sformatf("haddr[%0d]", i), haddr_o[i], job_base + 32'(4 * seen));
          if (in_phase)
            check_output($sformatf("hwdata[%0d]", i), hwdata_o[i], model_word(i, seen));
        end
        if (htrans_o[0] == 2'b10) begin
          if (nonseq_cnt < 16) wlog_addr[nonseq_cnt] = haddr_o[0];
          nonseq_cnt++;
        end
        if (in_phase) begin
          dlen++;
          if (HREADY) begin
            for (int i = 0; i < 2; i++) begin
              wlog_data[i][seen] = hwdata_o[i];
`ifdef MFP_RAM_LOADER_CHECKSUM_EN
              sum_m[i] = sum_m[i] + model_word(i, seen);
`endif
            end
            seen++;
            in_phase  = 1'b0;
            last_dlen = dlen;
            if (seen == job_cnt) done_arm = 1'b1;
          end
        end
        if (exp_ns) begin
          in_phase = 1'b1;
          dlen     = 0;
        end
        if (exp_rdy && rx_valid) begin
          hist[acc] = rx_data;
          acc++;
        end
        if (exp_done) active = 1'b0;
        if (start && start_real) begin
          active     = 1'b1;
          job_base   = base_addr;
          job_cnt    = int'(word_count);
          acc        = 0;
          seen       = 0;
          busy_cnt   = 0;
          nonseq_cnt = 0;
          sum_m[0]   = 32'd0;
          sum_m[1]   = 32'd0;
          if (word_count == 16'd0) done_arm = 1'b1;
        end
      end
    end
  end

  // Byte source: bit 8 set means a valid byte, clear means a one-cycle rx_valid gap.
  logic [8:0] feed[$];
  logic       feed_present = 1'b0;

  initial begin : feeder
    logic       took;
    logic [8:0] cur;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    cur      = 9'd0;
    forever begin
      @(negedge HCLK);
      took = rx_valid && rx_ready_o[0];
      @(posedge HCLK);
      #1;
      if (feed_present && (!cur[8] || took)) feed_present = 1'b0;
      if (!feed_present && feed.size() > 0) begin
        cur          = feed.pop_front();
        feed_present = 1'b1;
      end
      rx_valid = feed_present && cur[8];
      rx_data  = feed_present ? cur[7:0] : 8'h00;
    end
  end

  int stall_req = 0;

  initial begin : hready_drv
    HREADY = 1'b1;
    forever begin
      @(negedge HCLK);
      if (HRESETn && htrans_o[0] == 2'b10 && stall_req > 0) begin
        @(posedge HCLK);
        #1 HREADY = 1'b0;
        repeat (stall_req) @(posedge HCLK);
        #1 HREADY = 1'b1;
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] b, input logic [15:0] n, input logic is_real);
    @(posedge HCLK);
    #1;
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    start_real = is_real;
    @(posedge HCLK);
    #1;
    start      = 1'b0;
    start_real = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n   = 0;
    bit got = 0;
    while (!got && n < 300) begin
      @(negedge HCLK);
      if (done_o[0]) got = 1;
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no done pulse, expected one within 300 cycles", name);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_feed();
    for (int n = 0; n < 100; n++) begin
      @(posedge HCLK);
      #2;
      if (feed.size() == 0 && !feed_present) break;
    end
  endtask

  initial begin : stimulus
    HRESETn    = 1'b0;
    start      = 1'b0;
    start_real = 1'b0;
    base_addr  = 32'd0;
    word_count = 16'd0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Two back-to-back words, full-rate stream.
    foreach (feed[k]) feed.delete(k);
    feed.push_back(9'h111); feed.push_back(9'h122); feed.push_back(9'h133); feed.push_back(9'h144);
    feed.push_back(9'h155); feed.push_back(9'h166); feed.push_back(9'h177); feed.push_back(9'h188);
    apply_stimulus(32'h0000_0100, 16'd2, 1'b1);
    wait_done("s1_done");
    check_output("s1_nonseq_cnt", 32'(nonseq_cnt), 32'd2);
    check_output("s1_addr0", wlog_addr[0], 32'h0000_0100);
    check_output("s1_addr1", wlog_addr[1], 32'h0000_0104);
    check_output("s1_le_word0", wlog_data[0][0], 32'h4433_2211);
    check_output("s1_le_word1", wlog_data[0][1], 32'h8877_6655);
    check_output("s1_be_word0", wlog_data[1][0], 32'h1122_3344);
    check_output("s1_busy_cycles", 32'(busy_cnt), 32'd13);
`ifdef MFP_RAM_LOADER_CHECKSUM_EN
    check_output("s1_le_checksum", checksum_o[0], 32'hCCAA_8866);
    check_output("s1_be_checksum", checksum_o[1], 32'h6688_AACC);
`else
    check_output("s1_le_checksum", checksum_o[0], 32'h0000_0000);
    check_output("s1_be_checksum", checksum_o[1], 32'h0000_0000);
`endif

    // Zero-length load.
    apply_stimulus(32'h0000_0200, 16'd0, 1'b1);
    wait_done("s2_done");
    check_output("s2_busy_cycles", 32'(busy_cnt), 32'd1);
    check_output("s2_nonseq_cnt", 32'(nonseq_cnt), 32'd0);

    // Stream gaps plus a three-cycle HREADY stall in the data phase.
    stall_req = 3;
    feed.push_back(9'h101); feed.push_back(9'h000); feed.push_back(9'h102); feed.push_back(9'h000);
    feed.push_back(9'h000); feed.push_back(9'h103); feed.push_back(9'h104);
    apply_stimulus(32'h0000_2000, 16'd1, 1'b1);
    wait_done("s3_done");
    stall_req = 0;
    check_output("s3_nonseq_cnt", 32'(nonseq_cnt), 32'd1);
    check_output("s3_data_cycles", 32'(last_dlen), 32'd4);
    check_output("s3_le_word", wlog_data[0][0], 32'h0403_0201);
    check_output("s3_be_word", wlog_data[1][0], 32'h0102_0304);

    // Address wraps past the top of the 32-bit space.
    feed.push_back(9'h110); feed.push_back(9'h120); feed.push_back(9'h130); feed.push_back(9'h140);
    feed.push_back(9'h150); feed.push_back(9'h160); feed.push_back(9'h170); feed.push_back(9'h180);
    apply_stimulus(32'hFFFF_FFFC, 16'd2, 1'b1);
    wait_done("s4_done");
    check_output("s4_addr0", wlog_addr[0], 32'hFFFF_FFFC);
    check_output("s4_addr1", wlog_addr[1], 32'h0000_0000);
    check_output("s4_le_word1", wlog_data[0][1], 32'h8070_6050);

    // Reset after two bytes, then a fresh load with ignored start pulses while busy.
    feed.push_back(9'h1AA); feed.push_back(9'h1BB);
    apply_stimulus(32'h0000_0300, 16'd1, 1'b1);
    wait_feed();
    #1 HRESETn = 1'b0;
    #1;
    check_output("s5_async_busy", 32'(busy_o[0]), 32'd0);
    check_output("s5_async_rx_ready", 32'(rx_ready_o[0]), 32'd0);
    check_output("s5_async_hwdata", hwdata_o[0], 32'd0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    feed.push_back(9'h1A1); feed.push_back(9'h000); feed.push_back(9'h000); feed.push_back(9'h1B2);
    feed.push_back(9'h000); feed.push_back(9'h1C3); feed.push_back(9'h1D4);
    apply_stimulus(32'h0000_0400, 16'd1, 1'b1);
    apply_stimulus(32'h0000_0900, 16'd5, 1'b0);
    apply_stimulus(32'h0000_0A00, 16'd0, 1'b0);
    wait_done("s5_done");
    check_output("s5_nonseq_cnt", 32'(nonseq_cnt), 32'd1);
    check_output("s5_addr0", wlog_addr[0], 32'h0000_0400);
    check_output("s5_le_word", wlog_data[0][0], 32'hD4C3_B2A1);
    check_output("s5_be_word", wlog_data[1][0], 32'hA1B2_C3D4);

    repeat (3) @(posedge HCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_ram_loader.md
MFP_AHB_RAM_LOADER -- requirements
Module: mfp_ahb_ram_loader

Interface
REQ-001 The block SHALL have parameter BIG_ENDIAN, default 0; 0 packs the first received byte into HWDATA[7:0], 1 packs it into HWDATA[31:24].
REQ-002 The block SHALL have port HCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port HRESETn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a load.
REQ-005 The block SHALL have port base_addr, input, 32 bits: byte address of the first word, sampled on start, word-aligned.
REQ-006 The block SHALL have port word_count, input, 16 bits: number of words to load, sampled on start.
REQ-007 The block SHALL have port rx_data, input, 8 bits: the byte stream payload.
REQ-008 The block SHALL have port rx_valid, input, 1 bit: the byte stream valid.
REQ-009 The block SHALL have port rx_ready, output, 1 bit: the byte stream ready; a byte transfers when rx_valid and rx_ready are both high.
REQ-010 The block SHALL have port HADDR, output, 32 bits: the AHB-Lite master address.
REQ-011 The block SHALL have port HTRANS, output, 2 bits: the AHB-Lite master transfer type, IDLE or NONSEQ only.
REQ-012 The block SHALL have port HWRITE, output, 1 bit: the AHB-Lite master write flag.
REQ-013 The block SHALL have port HSIZE, output, 3 bits: the AHB-Lite master transfer size, constant 3'b010 (word).
REQ-014 The block SHALL have port HBURST, output, 3 bits: the AHB-Lite master burst type, constant SINGLE.
REQ-015 The block SHALL have port HWDATA, output, 32 bits: the AHB-Lite master write data.
REQ-016 The block SHALL have port HREADY, input, 1 bit: the slave ready; low extends the data phase.
REQ-017 The block SHALL have port busy, output, 1 bit: high from start until done; the system uses it to hold the CPU in reset.
REQ-018 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-019 The block SHALL have port checksum, output, 32 bits: the modulo-2^32 sum of the written words.

Function
REQ-020 The FSM SHALL have states IDLE, COLLECT, ADDR, DATA and FINISH.
REQ-021 IDLE: start with word_count>0 SHALL latch address and count, clear the byte index and checksum, and go to COLLECT; start with word_count=0 SHALL go to FINISH.
REQ-022 rx_ready SHALL be high only in COLLECT; each accepted byte SHALL be placed at lane index 0..3 per BIG_ENDIAN, and the 4th byte SHALL move the FSM to ADDR on the next edge.
REQ-023 ADDR (one cycle) SHALL drive HTRANS=NONSEQ, HWRITE=1, HADDR=current address; all other states SHALL drive HTRANS=IDLE, HWRITE=0.
REQ-024 DATA SHALL drive the assembled word on HWDATA and hold it while HREADY=0; on HREADY=1 the block SHALL add 4 to the address (wrapping at 2^32), decrement the count, and go to COLLECT if count>0, else to FINISH.
REQ-025 FINISH SHALL assert done for exactly one cycle and then return to IDLE.
REQ-026 busy SHALL be high in COLLECT, ADDR, DATA and FINISH.
REQ-027 start SHALL be ignored when not in IDLE.
REQ-028 Minimum per-word cost SHALL be 4 byte cycles + ADDR + DATA = 6 cycles.
REQ-029 rx_valid gaps SHALL stall COLLECT with no timeout.

Reset
REQ-030 HRESETn low SHALL immediately force IDLE and set HTRANS=IDLE, HWRITE=0, HADDR=0, HWDATA=0, rx_ready=0, busy=0, done=0 and checksum=0, including mid-transfer, discarding any partial word.

Configuration
REQ-031 With MFP_RAM_LOADER_CHECKSUM_EN defined, checksum SHALL accumulate each word in DATA when HREADY=1 and hold its value after done until the next start.
REQ-032 Without MFP_RAM_LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and no adder SHALL be synthesized.

Verification
REQ-033 Scenario: base_addr=0x0000_0100, word_count=2, bytes 11 22 33 44 55 66 77 88, BIG_ENDIAN=0, HREADY=1 -> writes 0x44332211@0x100 and 0x88776655@0x104; done one cycle after the second DATA; checksum=0xCCAA8866.
REQ-034 Scenario: BIG_ENDIAN=1, same bytes, word_count=1 -> HWDATA=0x11223344.
REQ-035 Scenario: word_count=0 -> busy high 1 cycle, done pulse, HTRANS never NONSEQ.
REQ-036 Scenario: HREADY low 3 cycles in DATA -> HWDATA stable for 4 cycles, rx_ready low throughout, single NONSEQ.
REQ-037 Scenario: base_addr=0xFFFF_FFFC, word_count=2 -> second write at 0x0000_0000.
REQ-038 Scenario: HRESETn low after 2 bytes, then a new start -> first write contains only post-reset bytes; start pulses during busy have no effect.
